// File: rtl/ysyx_25010008_axil_rd_master.sv
// Single-outstanding AXI4-Lite read master: client request/response in front, AR/R channels behind.
// Misaligned addresses are answered locally with an error and never reach the bus.
module ysyx_25010008_axil_rd_master #(
  parameter int unsigned LAT_MAX = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic [7:0]  resp_lat,
  output logic [15:0] done_cnt,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_e;

  localparam logic [7:0] LAT_SAT = 8'(LAT_MAX);

  state_e      state_q, state_d;
  logic [31:0] araddr_q, araddr_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        resp_err_q, resp_err_d;
  logic [7:0]  resp_lat_q, resp_lat_d;
  logic [7:0]  lat_q, lat_d;
  logic [15:0] done_cnt_q, done_cnt_d;
  logic [7:0]  lat_inc;

  assign lat_inc = (lat_q >= LAT_SAT) ? lat_q : lat_q + 8'd1;

  always_comb begin
    state_d      = state_q;
    araddr_d     = araddr_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    resp_lat_d   = resp_lat_q;
    lat_d        = lat_q;
    done_cnt_d   = done_cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          lat_d = 8'd0;
          if (req_addr[1:0] != 2'b00) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_data_d  = 32'd0;
            resp_err_d   = 1'b1;
            resp_lat_d   = 8'd0;
          end else begin
            state_d   = ADDR;
            araddr_d  = req_addr;
            arvalid_d = 1'b1;
          end
        end
      end
      ADDR: begin
        lat_d = lat_inc;
        // arvalid_q qualifies the handshake so an early arready is never mistaken for one.
        if (arvalid_q && arready) begin
          state_d   = DATA;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      DATA: begin
        lat_d = lat_inc;
        if (rready_q && rvalid) begin
          state_d      = RESP;
          rready_d     = 1'b0;
          resp_valid_d = 1'b1;
          resp_data_d  = rdata;
          resp_err_d   = (rresp != 2'b00);
          resp_lat_d   = lat_inc;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
          done_cnt_d   = done_cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      araddr_q     <= 32'd0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 32'd0;
      resp_err_q   <= 1'b0;
      resp_lat_q   <= 8'd0;
      lat_q        <= 8'd0;
      done_cnt_q   <= 16'd0;
    end else begin
      state_q      <= state_d;
      araddr_q     <= araddr_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
      resp_lat_q   <= resp_lat_d;
      lat_q        <= lat_d;
      done_cnt_q   <= done_cnt_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign araddr     = araddr_q;
  assign arvalid    = arvalid_q;
  assign rready     = rready_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;
  assign resp_lat   = resp_lat_q;
  assign done_cnt   = done_cnt_q;

endmodule

// File: tb/tb_ysyx_25010008_axil_rd_master.sv
// Bench for the AXI-Lite read master: the bench plays client and bus slave, and predicts
// every response from the delays it chose (latency = bus wait cycles + 2, capped at 255).
module tb_ysyx_25010008_axil_rd_master;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = 32'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_data;
  logic        resp_err;
  logic [7:0]  resp_lat;
  logic [15:0] done_cnt;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [31:0] rdata = 32'd0;
  logic [1:0]  rresp = 2'd0;
  logic        rvalid = 1'b0;
  logic        rready;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_done = 0;

  ysyx_25010008_axil_rd_master #(.LAT_MAX(255)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_err(resp_err), .resp_lat(resp_lat), .done_cnt(done_cnt),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // The two channel handshakes must never be open at the same time.
  always @(negedge clock) begin
    if (reset) check("ar_r_exclusive", 32'(arvalid && rready), 32'd0);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Called #1 after an edge with the DUT idle; returns #1 after the consuming edge.
  task automatic do_read(input logic [31:0] addr, input int ard, input int rd,
                         input logic [31:0] data, input logic [1:0] rr,
                         input int respd, input bit hold_req);
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;
    req_valid = 1'b1;
    req_addr  = addr;
    arready   = 1'($urandom_range(0, 1));
    rvalid    = 1'($urandom_range(0, 1));
    rdata     = $urandom;
    check("req_ready_idle", 32'(req_ready), 32'd1);
    tick();
    if (!hold_req) req_valid = 1'b0;
    if (addr[1:0] != 2'b00) begin
      check("misaligned_no_ar", 32'(arvalid), 32'd0);
      exp_data = 32'd0;
      exp_err  = 1'b1;
      exp_lat  = 0;
    end else begin
      check("arvalid_set", 32'(arvalid), 32'd1);
      check("araddr_set", araddr, addr);
      check("rready_low_in_addr", 32'(rready), 32'd0);
      for (int i = 0; i <= ard; i++) begin
        arready = (i == ard);
        rvalid  = 1'($urandom_range(0, 1));
        rdata   = $urandom;
        tick();
        if (i < ard) begin
          check("arvalid_held", 32'(arvalid), 32'd1);
          check("araddr_stable", araddr, addr);
        end
      end
      arready = 1'b0;
      check("arvalid_dropped", 32'(arvalid), 32'd0);
      check("rready_set", 32'(rready), 32'd1);
      for (int i = 0; i <= rd; i++) begin
        rvalid = (i == rd);
        rdata  = (i == rd) ? data : $urandom;
        rresp  = (i == rd) ? rr : 2'($urandom_range(0, 3));
        tick();
        if (i < rd) check("rready_held", 32'(rready), 32'd1);
      end
      rvalid   = 1'b0;
      exp_data = data;
      exp_err  = (rr != 2'b00);
      exp_lat  = (ard + 1) + (rd + 1);
      if (exp_lat > 255) exp_lat = 255;
    end
    for (int i = 0; i <= respd; i++) begin
      resp_ready = (i == respd);
      check("resp_valid", 32'(resp_valid), 32'd1);
      check("resp_data", resp_data, exp_data);
      check("resp_err", 32'(resp_err), 32'(exp_err));
      check("resp_lat", 32'(resp_lat), 32'(exp_lat));
      check("req_ready_busy", 32'(req_ready), 32'd0);
      tick();
    end
    resp_ready = 1'b0;
    exp_done   = (exp_done + 1) & 32'hFFFF;
    check("resp_valid_cleared", 32'(resp_valid), 32'd0);
    check("done_cnt", 32'(done_cnt), 32'(exp_done));
    check("req_ready_back", 32'(req_ready), 32'd1);
    $display("txn addr=0x%08h ard=%0d rd=%0d err=%0d lat=%0d data=0x%08h done=%0d",
             addr, ard, rd, exp_err, exp_lat, exp_data, exp_done);
  endtask

  initial begin
    int n;
    logic [31:0] a;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_arvalid", 32'(arvalid), 32'd0);
    check("rst_rready", 32'(rready), 32'd0);
    check("rst_araddr", araddr, 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_resp_lat", 32'(resp_lat), 32'd0);
    check("rst_done_cnt", 32'(done_cnt), 32'd0);
    tick();
    reset = 1'b1;

    do_read(32'h0200_BFF8, 0, 0, 32'h1234_5678, 2'd0, 0, 1'b0);
    do_read(32'h8000_0002, 0, 0, 32'h0, 2'd0, 0, 1'b0);
    do_read(32'h1000_0040, 5, 2, 32'hCAFE_F00D, 2'd2, 1, 1'b0);
    do_read(32'h2000_0000, 1, 1, 32'hA5A5_5A5A, 2'd0, 4, 1'b1);
    do_read(32'h2000_0004, 0, 1, 32'h0BAD_BEEF, 2'd3, 0, 1'b0);
    do_read(32'h3000_0100, 150, 150, 32'hFEED_FACE, 2'd0, 0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      do_read(a, int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), $urandom,
              2'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    // Reset while waiting for read data: the transaction vanishes without a response.
    req_valid = 1'b1;
    req_addr  = 32'h4000_0000;
    arready   = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    arready = 1'b0;
    check("pre_reset_rready", 32'(rready), 32'd1);
    reset = 1'b0;
    #1;
    check("async_rst_rready", 32'(rready), 32'd0);
    check("async_rst_arvalid", 32'(arvalid), 32'd0);
    check("async_rst_done", 32'(done_cnt), 32'd0);
    rvalid = 1'b1;
    tick();
    tick();
    check("in_rst_resp_valid", 32'(resp_valid), 32'd0);
    rvalid   = 1'b0;
    reset    = 1'b1;
    exp_done = 0;
    $display("txn reset mid-DATA, transaction abandoned");
    do_read(32'h4000_0010, 0, 0, 32'h0000_0001, 2'd0, 0, 1'b0);

    // Back-to-back misaligned reads, two cycles each, until done_cnt wraps.
    n          = 65536 - exp_done;
    req_valid  = 1'b1;
    req_addr   = 32'h0000_0003;
    resp_ready = 1'b1;
    repeat (2 * (n - 1)) @(posedge clock);
    #1;
    check("done_cnt_ffff", 32'(done_cnt), 32'h0000_FFFF);
    tick();
    tick();
    check("done_cnt_wrap", 32'(done_cnt), 32'd0);
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    exp_done   = 0;
    $display("txn %0d back-to-back misaligned reads, done_cnt wrapped", n);
    do_read(32'h0000_0020, 2, 0, 32'h7777_0000, 2'd1, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_25010008_axil_rd_master.md
YSYX_25010008_AXIL_RD_MASTER -- requirements
Module: ysyx_25010008_axil_rd_master

Interface
REQ-001 SHALL expose parameter LAT_MAX, default 255, meaning the saturation value of the latency counter (max 255).
REQ-002 SHALL have port clock  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-004 SHALL have port req_valid  input  1  client read request valid.
REQ-005 SHALL have port req_ready  output  1  request accepted when high with req_valid.
REQ-006 SHALL have port req_addr  input  32  client byte address.
REQ-007 SHALL have port resp_valid  output  1  response available to client.
REQ-008 SHALL have port resp_ready  input  1  client consumes response.
REQ-009 SHALL have port resp_data  output  32  read data.
REQ-010 SHALL have port resp_err  output  1  1 = misaligned or bus error.
REQ-011 SHALL have port resp_lat  output  8  cycles from acceptance to resp_valid, saturating.
REQ-012 SHALL have port done_cnt  output  16  completed responses, wraps.
REQ-013 SHALL have ports araddr output 32, arvalid output 1, arready input 1 (read-address channel).
REQ-014 SHALL have ports rdata input 32, rresp input 2, rvalid input 1, rready output 1 (read-data channel).

Function
REQ-015 SHALL implement states IDLE, ADDR, DATA, RESP; one transaction outstanding at most.
REQ-016 SHALL drive req_ready = 1 only in IDLE (combinational from state).
REQ-017 IDLE, req_valid=1 and req_addr[1:0]!=0: SHALL go RESP next cycle with resp_err=1, resp_data=0, no AR issued.
REQ-018 IDLE, req_valid=1 and aligned: SHALL register araddr=req_addr, set arvalid=1, go ADDR next cycle.
REQ-019 ADDR: arvalid and araddr SHALL stay constant until a cycle with arvalid&&arready; then arvalid<=0, rready<=1, go DATA.
REQ-020 arready high before arvalid SHALL NOT be treated as a handshake.
REQ-021 DATA: rready SHALL stay 1 until a cycle with rvalid&&rready; then capture resp_data=rdata, resp_err=(rresp!=0), rready<=0, go RESP.
REQ-022 rvalid while not in DATA SHALL be ignored (no capture, no state change).
REQ-023 RESP: resp_valid=1; resp_data, resp_err, resp_lat stable until resp_ready=1; then resp_valid<=0, go IDLE.
REQ-024 New request SHALL NOT be accepted in the RESP cycle of resp_ready; earliest acceptance one cycle later (IDLE).
REQ-025 Latency counter SHALL clear to 0 on acceptance, increment every cycle in ADDR and DATA, saturate at LAT_MAX; resp_lat = value at RESP entry (misaligned: 0).
REQ-026 done_cnt SHALL increment by 1 on each resp_valid&&resp_ready, wrapping 0xFFFF -> 0x0000.
REQ-027 No timeout: block SHALL wait indefinitely in ADDR or DATA.
REQ-028 SHALL never assert arvalid and rready in the same cycle.

Reset
REQ-029 reset=0 SHALL immediately (asynchronously) force IDLE, arvalid=0, rready=0, araddr=0, resp_valid=0, resp_data=0, resp_err=0, resp_lat=0, done_cnt=0.
REQ-030 Reset mid-transaction SHALL abandon it with no response; first acceptance possible on first rising edge with reset=1.

Verification
REQ-031 Aligned read 0x0200_BFF8, arready same cycle as arvalid, rvalid 1 cycle later with rdata=0x1234_5678, rresp=0 -> resp_data=0x1234_5678, resp_err=0, resp_lat=2, done_cnt=1.
REQ-032 req_addr=0x8000_0002 -> no arvalid ever, resp_valid next cycle, resp_err=1, resp_data=0, resp_lat=0.
REQ-033 arready held low 5 cycles, rvalid after 3 more, rresp=2 -> araddr stable throughout, resp_err=1, resp_lat=9.
REQ-034 resp_ready low 4 cycles in RESP, req_valid high throughout -> outputs stable, req_ready=0 until IDLE, second request accepted one cycle after consumption.
REQ-035 arready/rvalid withheld 300 cycles -> resp_lat=255; reset pulsed low in DATA -> rready=0 at once, no resp_valid, done_cnt=0.
REQ-036 65536 back-to-back reads -> done_cnt wraps to 0x0000.
